// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: shift-and-add-3 binary-to-BCD converter, one input bit per clock, feeding the 7-segment display driver.
// Optional macro BIN2BCD_OVF_ERR_EN: overflowing inputs show 16'hEEEE instead of saturating to 16'h9999.
`default_nettype none

module bin2bcd_seq #(
  parameter int IN_WIDTH = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  input  logic [IN_WIDTH-1:0] i_bin,
  output logic                o_ready,
  output logic [15:0]         o_data,
  output logic                o_we
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);
`ifdef BIN2BCD_OVF_ERR_EN
  localparam logic [15:0] c_OVF_PATTERN = 16'hEEEE;
`else
  localparam logic [15:0] c_OVF_PATTERN = 16'h9999;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_bin;
  logic [15:0]         r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0]         w_adj;
  logic [15:0]         w_bcd_next;
  logic                w_accept;
  logic                w_ovf;

  assign o_ready  = (r_state == S_IDLE);
  assign w_accept = o_ready & i_valid;

  // Nibbles are adjusted independently; no carry crosses a digit boundary.
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? (r_bcd[4*g +: 4] + 4'd3)
                                                        : r_bcd[4*g +: 4];
  end

  assign w_bcd_next = (w_adj << 1) | {15'd0, r_bin[IN_WIDTH-1]};

  // Only a 14-bit input can exceed four decimal digits.
  if (IN_WIDTH == 14) begin : g_ovf
    logic r_ovf;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ovf <= 1'b0;
      end else if (w_accept) begin
        r_ovf <= ({{(32-IN_WIDTH){1'b0}}, i_bin} > 32'd9999);
      end
    end
    assign w_ovf = r_ovf;
  end else begin : g_no_ovf
    assign w_ovf = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      o_data  <= 16'h0000;
      o_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_we <= 1'b0;
          if (i_valid) begin
            r_bin   <= i_bin;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(IN_WIDTH);
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_next;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            o_data  <= w_ovf ? c_OVF_PATTERN : w_bcd_next;
            o_we    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          o_we    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_we    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized self-checking bench for bin2bcd_seq against a decimal-arithmetic reference.
`default_nettype none

module tb_bin2bcd_seq;

  localparam int IN_WIDTH = 14;
`ifdef BIN2BCD_OVF_ERR_EN
  localparam logic [15:0] c_OVF = 16'hEEEE;
`else
  localparam logic [15:0] c_OVF = 16'h9999;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_valid = 1'b0;
  logic [IN_WIDTH-1:0] i_bin = '0;
  logic                o_ready;
  logic [15:0]         o_data;
  logic                o_we;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int exp_we   = 0;

  bin2bcd_seq #(.IN_WIDTH(IN_WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(i_valid),
    .i_bin  (i_bin),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_we   (o_we)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_we) we_cnt++;

  function automatic logic [15:0] model(input int v);
    logic [3:0] d3, d2, d1, d0;
    if (v > 9999) return c_OVF;
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept edge counts as edge 1; o_we must appear after edge IN_WIDTH+1.
  task automatic convert(input int v);
    bit ok;
    bit early;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = o_ready;
    end
    if (!ok) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    i_valid = 1'b1;
    i_bin   = IN_WIDTH'(v);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_bin   = IN_WIDTH'($urandom);
    check("busy_after_accept", {31'd0, o_ready}, 32'd0);
    early = 1'b0;
    for (int k = 2; k <= IN_WIDTH + 1; k++) begin
      if (k > 2) begin
        @(negedge clk);
        i_bin = IN_WIDTH'($urandom);
      end
      @(posedge clk); #1;
      if (k <= IN_WIDTH && o_we) early = 1'b1;
    end
    check("we_early", {31'd0, early}, 32'd0);
    check("we_latency", {31'd0, o_we}, 32'd1);
    check("data", {16'd0, o_data}, {16'd0, model(v)});
    exp_we++;
    @(posedge clk); #1;
    check("we_one_cycle", {31'd0, o_we}, 32'd0);
    check("ready_after", {31'd0, o_ready}, 32'd1);
    check("data_hold", {16'd0, o_data}, {16'd0, model(v)});
  endtask

  initial begin
    bit seen_we;
    bit bad_idle;
    int n, acc, got, last;
    int q[$];

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen_we = 1'b0;
    bad_idle = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (o_we) seen_we = 1'b1;
      if (o_data !== 16'h0000 || o_ready !== 1'b1) bad_idle = 1'b1;
    end
    check("reset_we", {31'd0, seen_we}, 32'd0);
    check("reset_idle", {31'd0, bad_idle}, 32'd0);
    check("reset_data", {16'd0, o_data}, 32'd0);

    convert(1234);
    convert(0);
    convert(9);
    convert(10);
    convert(9999);
    convert(10000);
    convert(16383);
    for (int r = 0; r < 12; r++) convert(int'($urandom_range(0, 16383)));

    // Held i_valid: accepts 0,1,2 with junk on i_bin while busy.
    n = 0; acc = 0; got = 0; last = -1;
    for (int cyc = 0; cyc < 80 && got < 3; cyc++) begin
      @(negedge clk);
      if (o_ready && acc < 3) begin
        i_valid = 1'b1;
        i_bin   = IN_WIDTH'(n);
        q.push_back(n);
        n++;
        acc++;
      end else begin
        i_valid = (acc < 3);
        i_bin   = IN_WIDTH'($urandom);
      end
      @(posedge clk); #1;
      if (o_we) begin
        check("b2b_data", {16'd0, o_data}, {16'd0, model(q.pop_front())});
        if (last >= 0) check("b2b_period", cyc - last, IN_WIDTH + 2);
        last = cyc;
        got++;
      end
    end
    i_valid = 1'b0;
    check("b2b_count", got, 3);
    exp_we += 3;

    // Abort mid-conversion with an asynchronous reset.
    @(negedge clk);
    i_valid = 1'b1;
    i_bin   = IN_WIDTH'(4321);
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_data", {16'd0, o_data}, 32'd0);
    check("abort_ready", {31'd0, o_ready}, 32'd1);
    check("abort_we", {31'd0, o_we}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    convert(42);

    repeat (5) @(posedge clk);
    check("we_total", we_cnt, exp_we);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) in the CPU display path.
- Accepts an unsigned binary value from the CPU I/O write path and produces four packed BCD digits plus a one-cycle write strobe.
- Its o_data/o_we pair connects directly to the data/write-enable inputs of the 4-digit 7-segment display driver, so the display shows decimal instead of hex.

Parameters:
- IN_WIDTH, 14: binary input width; legal range 4..14. Values above 9999 are possible only when IN_WIDTH = 14.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- i_valid  input  1  new value present on i_bin
- i_bin  input  IN_WIDTH  unsigned binary value to convert
- o_ready  output  1  converter idle; i_valid accepted this cycle
- o_data  output  16  packed BCD {thousands, hundreds, tens, ones}, 4 bits each
- o_we  output  1  one-cycle strobe; o_data holds a new result

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. State goes to IDLE; o_data = 16'h0000; o_we = 0; o_ready = 1.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- o_ready = (state == IDLE). It is combinational from the state register.
- IDLE:
  - On a clock edge with i_valid & o_ready, latch i_bin into the binary shift register.
  - Clear the 16-bit BCD accumulator.
  - Load the iteration counter with IN_WIDTH.
  - Latch the overflow flag (i_bin > 9999).
  - Go to SHIFT.
- SHIFT, one bit per cycle:
  - Each BCD nibble >= 5 gets +3, in 4-bit arithmetic with no carry between nibbles.
  - Then shift {bcd, bin} left by 1; bin MSB enters bcd LSB.
  - Decrement the counter. The edge that performs the IN_WIDTH-th shift moves to DONE.
- DONE, exactly one cycle:
  - o_we = 1.
  - o_data was registered on the entering edge: the BCD accumulator, or the overflow pattern if the overflow flag is set.
  - Next edge goes to IDLE.
- Latency: o_we is high during the cycle that begins IN_WIDTH+1 edges after the accepting edge. Throughput is one conversion per IN_WIDTH+2 cycles, so back-to-back is IN_WIDTH+2 when i_valid is held high.
- o_data is stable outside DONE. It holds the last result until the next DONE and is never partially updated.
- o_we is high for exactly one cycle per accepted input and never without an accepted input.
- i_valid while busy (o_ready = 0) is ignored, not queued. i_bin is sampled only on the accepting edge and may change afterwards.
- The counter is sized $clog2(IN_WIDTH+1) and never wraps.
- Reset mid-conversion aborts immediately: no o_we, o_data = 0, o_ready = 1 from the reset assertion onward.
- Overflow pattern: 16'h9999 (saturate), unless the optional feature below is enabled.
- If i_valid rises on the same cycle as DONE, it is not accepted; acceptance happens on the following IDLE cycle.

Optional Feature:
- Macro BIN2BCD_OVF_ERR_EN.
- Defined: when the overflow flag is set, DONE writes o_data = 16'hEEEE, which the display shows as "EEEE".
- Not defined: overflowing inputs saturate to 16'h9999.
- The overflow comparator and flag register exist only when IN_WIDTH = 14; otherwise the flag is tied 0 in both builds.
- Latency, handshake and the o_we strobe are identical in both builds.

Test Plan:
- Reset, then hold idle 20 cycles -> o_data = 16'h0000, o_we never high, o_ready = 1.
- i_bin = 1234 for one cycle with i_valid -> o_ready low next cycle; o_we high exactly 15 cycles after the accepting edge (IN_WIDTH = 14) with o_data = 16'h1234; o_ready high the cycle after.
- Boundaries: i_bin = 0 -> 16'h0000; 9 -> 16'h0009; 10 -> 16'h0010; 9999 -> 16'h9999; each with a single o_we.
- Overflow: i_bin = 10000 and 16383 -> o_data = 16'h9999 (macro off) or 16'hEEEE (macro on).
- i_valid held high with i_bin stepping 0,1,2,... on each accept -> o_we every 16 cycles; results 16'h0000, 16'h0001, 16'h0002; i_bin changes while busy are ignored.
- Accept 4321, assert rst_n low at cycle 7 of SHIFT for 2 cycles -> no o_we, o_data = 0. Then accept 42 -> o_data = 16'h0042 after 15 cycles.
